// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite subordinate terminating requests in a small word-addressed memory.
// It has independent single-outstanding write and read paths, each with a fixed response latency.
package axi_lite_mem_responder_pkg;
    typedef struct packed { logic [31:0] addr; logic [2:0] prot; } axi_lite_ax_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } axi_lite_w_t;
    typedef struct packed { logic [1:0] resp; } axi_lite_b_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } axi_lite_r_t;
    typedef struct packed {
        axi_lite_ax_t aw; logic aw_valid;
        axi_lite_w_t  w;  logic w_valid;
        logic         b_ready;
        axi_lite_ax_t ar; logic ar_valid;
        logic         r_ready;
    } axi_lite_req_t;
    typedef struct packed {
        logic aw_ready; logic w_ready;
        axi_lite_b_t b; logic b_valid;
        logic ar_ready;
        axi_lite_r_t r; logic r_valid;
    } axi_lite_resp_t;
endpackage

module axi_lite_mem_responder
    import axi_lite_mem_responder_pkg::*;
#(
    parameter type         axi_req_t   = axi_lite_req_t,
    parameter type         axi_resp_t  = axi_lite_resp_t,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumWords    = 16,
    parameter int unsigned RespLatency = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned Off       = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(NumWords);
    localparam logic [7:0]  Lat       = 8'(RespLatency);
    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

    w_state_e               w_state_q, w_state_d;
    r_state_e               r_state_q, r_state_d;
    logic [7:0]             w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
    logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AddrWidth-1:0]   aw_addr_q, aw_addr_d;
    logic [DataWidth-1:0]   w_data_q, w_data_d;
    logic [StrbWidth-1:0]   w_strb_q, w_strb_d;
    logic [1:0]             b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [DataWidth-1:0]   r_data_q, r_data_d;
    logic [DataWidth-1:0]   mem_q [NumWords];

    logic                   aw_ready, w_ready, ar_ready, aw_hs, w_hs, commit;
    logic [AddrWidth-1:0]   wr_addr, rd_addr;
    logic [DataWidth-1:0]   wr_data;
    logic [StrbWidth-1:0]   wr_strb;
    logic                   unused_prot;

    function automatic logic is_oor(input logic [AddrWidth-1:0] a);
        return (a >> Off) >= AddrWidth'(NumWords);
    endfunction

    function automatic logic [IdxWidth-1:0] word_idx(input logic [AddrWidth-1:0] a);
        return a[Off +: IdxWidth];
    endfunction

    assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

    // Readiness depends only on registered state, so no input reaches an output combinationally.
    assign aw_ready = (w_state_q == W_IDLE) && !aw_held_q;
    assign w_ready  = (w_state_q == W_IDLE) && !w_held_q;
    assign ar_ready = (r_state_q == R_IDLE);
    assign aw_hs    = aw_ready && slv_req_i.aw_valid;
    assign w_hs     = w_ready && slv_req_i.w_valid;
    assign commit   = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_addr  = aw_held_q ? aw_addr_q : AddrWidth'(slv_req_i.aw.addr);
    assign wr_data  = w_held_q ? w_data_q : DataWidth'(slv_req_i.w.data);
    assign wr_strb  = w_held_q ? w_strb_q : StrbWidth'(slv_req_i.w.strb);
    assign rd_addr  = AddrWidth'(slv_req_i.ar.addr);

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_resp_d  = b_resp_q;
        case (w_state_q)
            W_IDLE: begin
                if (commit) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    b_resp_d  = is_oor(wr_addr) ? RespSlvErr : RespOkay;
                    // Skipping W_WAIT at zero latency gives b_valid the cycle after commit.
                    if (Lat == 8'd0) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_WAIT;
                        w_cnt_d   = Lat - 8'd1;
                    end
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        aw_addr_d = AddrWidth'(slv_req_i.aw.addr);
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        w_data_d = DataWidth'(slv_req_i.w.data);
                        w_strb_d = StrbWidth'(slv_req_i.w.strb);
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt_q == 8'd0) w_state_d = W_RESP;
                else                 w_cnt_d   = w_cnt_q - 8'd1;
            end
            W_RESP:  if (slv_req_i.b_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        case (r_state_q)
            R_IDLE: begin
                if (slv_req_i.ar_valid) begin
                    // Memory is sampled before this edge's write lands, so a same-cycle write is not seen.
                    r_data_d = is_oor(rd_addr) ? '0 : mem_q[word_idx(rd_addr)];
                    r_resp_d = is_oor(rd_addr) ? RespSlvErr : RespOkay;
                    if (Lat == 8'd0) begin
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_WAIT;
                        r_cnt_d   = Lat - 8'd1;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 8'd0) r_state_d = R_RESP;
                else                 r_cnt_d   = r_cnt_q - 8'd1;
            end
            R_RESP:  if (slv_req_i.r_ready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_cnt_q   <= '0;
            r_cnt_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= '0;
            r_resp_q  <= '0;
            r_data_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_cnt_q   <= w_cnt_d;
            r_cnt_q   <= r_cnt_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_resp_q  <= b_resp_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
        end else if (commit && !is_oor(wr_addr)) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (wr_strb[b]) mem_q[word_idx(wr_addr)][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.b_valid  = (w_state_q == W_RESP);
        slv_resp_o.b.resp   = b_resp_q;
        slv_resp_o.r_valid  = (r_state_q == R_RESP);
        slv_resp_o.r.data   = r_data_q;
        slv_resp_o.r.resp   = r_resp_q;
    end
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Bench for axi_lite_mem_responder: directed vector table, multi-cycle corner sequences,
// then random single transactions checked against a word-array reference model.
module tb_axi_lite_mem_responder;
    import axi_lite_mem_responder_pkg::*;

    localparam int Lat = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    axi_lite_req_t  req;
    axi_lite_resp_t rsp;
    int             checks = 0;
    int             errors = 0;
    logic [31:0]    model_mem [16];

    always #5 clk = ~clk;

    axi_lite_mem_responder #(
        .axi_req_t  (axi_lite_req_t),
        .axi_resp_t (axi_lite_resp_t),
        .AddrWidth  (32),
        .DataWidth  (32),
        .NumWords   (16),
        .RespLatency(Lat)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .slv_req_i (req),
        .slv_resp_o(rsp)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, want);
        end
    endtask

    // Reference model: plain word array, byte-lane merge, out-of-range words ignored.
    function automatic logic in_range(input logic [31:0] a);
        return (a / 4) < 16;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return in_range(a) ? model_mem[a / 4] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[a / 4][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bp, output logic [1:0] resp, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!(rsp.aw_ready && rsp.w_ready) && n < 50) begin @(negedge clk); n++; end
        check("wr_ready", rsp.aw_ready && rsp.w_ready, 1);
        req.aw.addr = a; req.aw.prot = 3'($urandom); req.aw_valid = 1'b1;
        req.w.data = d; req.w.strb = s; req.w_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            req.aw_valid = 1'b0; req.w_valid = 1'b0;
            lat++;
        end while (!rsp.b_valid && lat < 50);
        check("wr_b_seen", rsp.b_valid, 1);
        resp = rsp.b.resp;
        repeat (bp) begin
            @(negedge clk);
            check("b_hold_valid", rsp.b_valid, 1);
            check("b_hold_resp", rsp.b.resp, resp);
        end
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        check("b_drop", rsp.b_valid, 0);
        $display("write addr=%h data=%h strb=%h resp=%0d lat=%0d", a, d, s, resp, lat);
    endtask

    task automatic do_read(input logic [31:0] a, input int bp,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!rsp.ar_ready && n < 50) begin @(negedge clk); n++; end
        check("rd_ready", rsp.ar_ready, 1);
        req.ar.addr = a; req.ar.prot = 3'($urandom); req.ar_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            req.ar_valid = 1'b0;
            lat++;
        end while (!rsp.r_valid && lat < 50);
        check("rd_r_seen", rsp.r_valid, 1);
        data = rsp.r.data;
        resp = rsp.r.resp;
        repeat (bp) begin
            @(negedge clk);
            check("r_hold_valid", rsp.r_valid, 1);
            check("r_hold_data", rsp.r.data, data);
            check("r_hold_resp", rsp.r.resp, resp);
        end
        req.r_ready = 1'b1;
        @(negedge clk);
        req.r_ready = 1'b0;
        check("r_drop", rsp.r_valid, 0);
        $display("read  addr=%h data=%h resp=%0d lat=%0d", a, data, resp, lat);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] want;
        int          lat;
        int          n;

        vecs[0]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'hDEADBEEF,  4'hF, 2'b00, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 32'h0000_0004, 32'h11223344,  4'hF, 2'b00, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0004, 32'hAABBCCDD,  4'h5, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h11BB33DD};
        vecs[6]  = '{1'b1, 32'h0000_0040, 32'hCAFEF00D,  4'hF, 2'b10, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'h12345678,  4'h8, 2'b00, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_003F, 32'h0,         4'h0, 2'b00, 32'h12000000};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};

        req = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_aw_ready", rsp.aw_ready, 1);
        check("rst_w_ready", rsp.w_ready, 1);
        check("rst_ar_ready", rsp.ar_ready, 1);
        check("rst_b_valid", rsp.b_valid, 0);
        check("rst_r_valid", rsp.r_valid, 0);
        check("rst_b_resp", rsp.b.resp, 0);
        check("rst_r_data", rsp.r.data, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, resp, lat);
                check("vec_b_resp", resp, vecs[i].exp_resp);
                check("vec_b_lat", lat, 1 + Lat);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                do_read(vecs[i].addr, i % 3, data, resp, lat);
                check("vec_r_resp", resp, vecs[i].exp_resp);
                check("vec_r_data", data, vecs[i].exp_data);
                check("vec_r_lat", lat, 1 + Lat);
            end
        end

        // W arrives two cycles before AW.
        @(negedge clk);
        req.w.data = 32'h0BADF00D; req.w.strb = 4'hF; req.w_valid = 1'b1;
        @(negedge clk);
        req.w_valid = 1'b0;
        check("ord_w_ready_low", rsp.w_ready, 0);
        check("ord_aw_ready_high", rsp.aw_ready, 1);
        check("ord_no_b_yet", rsp.b_valid, 0);
        @(negedge clk);
        check("ord_w_ready_still_low", rsp.w_ready, 0);
        req.aw.addr = 32'h14; req.aw_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        n = 3;
        while (!rsp.b_valid && n < 40) begin
            check("ord_aw_ready_wait", rsp.aw_ready, 0);
            @(negedge clk);
            n++;
        end
        check("ord_b_lat", n, 3 + Lat);
        check("ord_aw_ready_resp", rsp.aw_ready, 0);
        check("ord_b_resp", rsp.b.resp, 2'b00);
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        check("ord_aw_ready_back", rsp.aw_ready, 1);
        model_write(32'h14, 32'h0BADF00D, 4'hF);
        $display("write addr=00000014 data=0badf00d strb=f (w before aw) lat=%0d", n);

        // AR in the same cycle as a write commit to the same word returns the old data.
        do_write(32'h8, 32'h55555555, 4'hF, 0, resp, lat);
        model_write(32'h8, 32'h55555555, 4'hF);
        want = model_read(32'h8);
        @(negedge clk);
        req.aw.addr = 32'h8; req.w.data = 32'h66666666; req.w.strb = 4'hF;
        req.aw_valid = 1'b1; req.w_valid = 1'b1;
        req.ar.addr = 32'h8; req.ar_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
        n = 1;
        while (!(rsp.b_valid && rsp.r_valid) && n < 40) begin @(negedge clk); n++; end
        check("sim_lat", n, 1 + Lat);
        check("sim_old_data", rsp.r.data, want);
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0; req.r_ready = 1'b0;
        model_write(32'h8, 32'h66666666, 4'hF);
        $display("simul addr=00000008 old=%h lat=%0d", want, n);
        do_read(32'h8, 0, data, resp, lat);
        check("sim_new_data", data, model_read(32'h8));

        // Backpressure on both channels, then reset while responses are pending.
        want = model_read(32'h14);
        @(negedge clk);
        req.aw.addr = 32'h20; req.w.data = 32'h77777777; req.w.strb = 4'hF;
        req.aw_valid = 1'b1; req.w_valid = 1'b1;
        req.ar.addr = 32'h14; req.ar_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
        n = 1;
        while (!(rsp.b_valid && rsp.r_valid) && n < 40) begin @(negedge clk); n++; end
        check("bp_both_valid", rsp.b_valid && rsp.r_valid, 1);
        check("bp_rdata", rsp.r.data, want);
        repeat (10) begin
            @(negedge clk);
            check("bp_b_valid", rsp.b_valid, 1);
            check("bp_b_resp", rsp.b.resp, 2'b00);
            check("bp_r_valid", rsp.r_valid, 1);
            check("bp_r_data", rsp.r.data, want);
            check("bp_r_resp", rsp.r.resp, 2'b00);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mrst_b_valid", rsp.b_valid, 0);
        check("mrst_r_valid", rsp.r_valid, 0);
        check("mrst_aw_ready", rsp.aw_ready, 1);
        check("mrst_w_ready", rsp.w_ready, 1);
        check("mrst_ar_ready", rsp.ar_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_b_valid", rsp.b_valid, 0);
            check("post_rst_r_valid", rsp.r_valid, 0);
        end
        req.b_ready = 1'b0; req.r_ready = 1'b0;
        $display("reset during backpressure, responses discarded");
        do_read(32'h14, 0, data, resp, lat);
        check("post_rst_mem", data, model_read(32'h14));

        // A held W is discarded by reset: a later AW alone must not commit.
        @(negedge clk);
        req.w.data = 32'hBAD0BAD0; req.w.strb = 4'hF; req.w_valid = 1'b1;
        @(negedge clk);
        req.w_valid = 1'b0;
        check("held_w_ready_low", rsp.w_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req.aw.addr = 32'h0; req.aw_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        repeat (6) begin
            check("held_no_b", rsp.b_valid, 0);
            @(negedge clk);
        end
        req.w.data = 32'h99999999; req.w.strb = 4'hF; req.w_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            req.w_valid = 1'b0;
            n++;
        end while (!rsp.b_valid && n < 40);
        check("held_b_lat", n, 1 + Lat);
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        model_clear();
        model_write(32'h0, 32'h99999999, 4'hF);
        $display("write addr=00000000 data=99999999 (aw held across idle) lat=%0d", n);
        do_read(32'h0, 0, data, resp, lat);
        check("held_read", data, model_read(32'h0));

        // Random single transactions against the model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            int          bp;
            a  = 32'($urandom_range(0, 32'h4F));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            bp = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, bp, resp, lat);
                check("rnd_b_resp", resp, model_resp(a));
                check("rnd_b_lat", lat, 1 + Lat);
                model_write(a, d, s);
            end else begin
                do_read(a, bp, data, resp, lat);
                check("rnd_r_resp", resp, model_resp(a));
                check("rnd_r_data", data, model_read(a));
                check("rnd_r_lat", lat, 1 + Lat);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
